// File: rtl/alu_hs.sv
// alu_hs: registered ALU with a valid/ready handshake on input and output.
// A single-cycle op is accepted and its result is held in DONE until the
// consumer takes it. The optional iterative shift-add multiplier (op 1010)
// is built only when the macro ALU_MUL_EN is defined. Without the macro,
// op 1010 behaves like any undefined opcode.
module alu_hs #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         z,
    output logic         c,
    output logic         v,
    output logic         n,
    output logic         busy
);

    localparam int SW = $clog2(N);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   result_q, result_d;
    logic           z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d;

    logic           is_sub;
    logic [N-1:0]   b_eff;
    logic [N:0]     sum;
    logic           ovf;
    logic [SW-1:0]  shamt;
    logic [N-1:0]   alu_res;
    logic           alu_c;
    logic           alu_v;
    logic           accept;

`ifdef ALU_MUL_EN
    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   acc_step;
`endif

    // SUB, SLT and SLTU share one a + ~b + 1 adder, so signed/unsigned compares reuse its flags
    always_comb begin
        is_sub  = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        b_eff   = is_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
        ovf     = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);
        shamt   = b[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = ovf;
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(N-1){1'b0}}, sum[N-1] ^ ovf};
            OP_SLTU: alu_res = {{(N-1){1'b0}}, ~sum[N]};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Handshake outputs decoded from the state; in_ready is held low during reset
    always_comb begin
        in_ready  = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
        out_valid = (state_q == S_DONE);
`ifdef ALU_MUL_EN
        busy      = (state_q == S_MUL);
`else
        busy      = 1'b0;
`endif
        accept    = in_valid && in_ready;
        result    = result_q;
        z         = z_q;
        c         = c_q;
        v         = v_q;
        n         = n_q;
    end

`ifdef ALU_MUL_EN
    // One shift-add step: add the multiplicand when the multiplier LSB is set
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    end
`endif

    // Next-state: load on accept, release on consume, iterate the multiplier
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        n_d      = n_q;
`ifdef ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        if ((state_q == S_DONE) && out_ready && !accept) begin
            state_d = S_IDLE;
        end
        if (accept) begin
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
                mcand_d  = a;
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = SW'(N - 1);
                state_d  = S_MUL;
            end else begin
`endif
                result_d = alu_res;
                z_d      = (alu_res == '0);
                n_d      = alu_res[N-1];
                c_d      = alu_c;
                v_d      = alu_v;
                state_d  = S_DONE;
`ifdef ALU_MUL_EN
            end
`endif
        end
`ifdef ALU_MUL_EN
        if (state_q == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
                result_d = acc_step;
                z_d      = (acc_step == '0);
                n_d      = acc_step[N-1];
                c_d      = 1'b0;
                v_d      = 1'b0;
                state_d  = S_DONE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
`endif
    end

    // State and output registers; async reset returns to IDLE with everything cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            n_q      <= n_d;
`ifdef ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: self-checking bench for alu_hs (N = 32) with a behavioural
// reference model. Covers the ALU_MUL_EN multiplier when that macro is defined.
module tb_alu_hs;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [3:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;
    logic          z, c, v, n;
    logic          busy;

    int passed;
    int total;

    alu_hs #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .c         (c),
        .v         (v),
        .n         (n),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs despite the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Reference model: returns {result, z, c, v, n} from plain arithmetic
    function automatic logic [N+3:0] model(input logic [3:0] mop, input logic [N-1:0] ma, input logic [N-1:0] mb);
        logic [N-1:0] r;
        logic         mc, mv;
        logic [N:0]   wide;
        longint       sa, sb, s;
        logic [63:0]  prod;
        sa = $signed(ma);
        sb = $signed(mb);
        r  = '0;
        mc = 1'b0;
        mv = 1'b0;
        case (mop)
            4'd0: begin
                wide = {1'b0, ma} + {1'b0, mb};
                r    = wide[N-1:0];
                mc   = wide[N];
                s    = sa + sb;
                mv   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r  = ma - mb;
                mc = (ma >= mb);
                s  = sa - sb;
                mv = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = ma & mb;
            4'd3: r = ma | mb;
            4'd4: r = ma ^ mb;
            4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: r = (ma < mb) ? 32'd1 : 32'd0;
            4'd7: r = ma << mb[4:0];
            4'd8: r = ma >> mb[4:0];
            4'd9: r = $signed(ma) >>> mb[4:0];
`ifdef ALU_MUL_EN
            4'd10: begin
                prod = {32'd0, ma} * {32'd0, mb};
                r    = prod[N-1:0];
            end
`endif
            default: r = '0;
        endcase
        return {r, (r == '0), mc, mv, r[N-1]};
    endfunction

    // Operand source biased toward corner values
    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drives one request, waits for the result; reports latency and whether busy/in_ready looked right while waiting
    task automatic send_op(input logic [3:0] sop, input logic [N-1:0] sa, input logic [N-1:0] sb,
                           output logic [N+3:0] got, output int lat, output logic timed_out, output logic wait_ok);
        int guard;
        timed_out = 1'b0;
        wait_ok   = 1'b1;
        @(negedge clk);
        op       = sop;
        a        = sa;
        b        = sb;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) timed_out = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 4'($urandom);
        lat      = 0;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) wait_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) timed_out = 1'b1;
        got = {result, z, c, v, n};
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        op        = 4'd0;
        a         = 32'h1234_5678;
        b         = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        else passed++;
        total++;
        if ({out_valid, busy} !== 2'b00) $display("[TB] FAIL reset_valid_busy: got %b expected 00", {out_valid, busy});
        else passed++;
        total++;
        if ({result, z, c, v, n} !== '0) $display("[TB] FAIL reset_result_flags: got %h expected 0", {result, z, c, v, n});
        else passed++;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0]   t_op [10] = '{4'd0, 4'd0, 4'd1, 4'd5, 4'd6, 4'd5, 4'd6, 4'd9, 4'd8, 4'd2};
        logic [N-1:0] t_a  [10] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd3, 32'd3, 32'd3, 32'h80000000, 32'h80000000, 32'hF0000000, 32'hF0000000, 32'hF0F0F0F0};
        logic [N-1:0] t_b  [10] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd5, 32'd1, 32'd1, 32'd4, 32'd4, 32'h0FF00FF0};
        logic [N-1:0] t_r  [10] = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'd1, 32'd1, 32'd1, 32'd0, 32'hFF000000, 32'h0F000000, 32'h00F000F0};
        logic [3:0]   t_f  [10] = '{4'b1100, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
        logic [N+3:0] got;
        int           lat;
        logic         to, wok;
        for (int i = 0; i < 10; i++) begin
            send_op(t_op[i], t_a[i], t_b[i], got, lat, to, wok);
            total++;
            if (to || lat != 0) $display("[TB] FAIL directed_latency[%0d]: got %0d timeout=%b expected 0", i, lat, to);
            else passed++;
            total++;
            if (got !== {t_r[i], t_f[i]}) $display("[TB] FAIL directed[%0d]: got res=%h zcvn=%b expected res=%h zcvn=%b", i, got[N+3:4], got[3:0], t_r[i], t_f[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [3:0]   rop;
        logic [N-1:0] ra, rb;
        logic [N+3:0] got, exp;
        int           lat;
        logic         to, wok;
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = pick();
            rb  = pick();
            exp = model(rop, ra, rb);
            send_op(rop, ra, rb, got, lat, to, wok);
            total++;
            if (to || got !== exp)
                $display("[TB] FAIL random op=%0d a=%h b=%h: got res=%h zcvn=%b timeout=%b expected res=%h zcvn=%b", rop, ra, rb, got[N+3:4], got[3:0], to, exp[N+3:4], exp[3:0]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   rop;
        logic [N-1:0] ra, rb;
        logic [N+3:0] exp, held;
        out_ready = 1'b1;
        held      = '0;
        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(0, 9));
            ra  = pick();
            rb  = pick();
            exp = model(rop, ra, rb);
            @(negedge clk);
            op = rop; a = ra; b = rb; in_valid = 1'b1;
            total++;
            if (in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || {result, z, c, v, n} !== exp)
                $display("[TB] FAIL b2b_result[%0d]: got valid=%b res=%h zcvn=%b expected valid=1 res=%h zcvn=%b", i, out_valid, result, {z, c, v, n}, exp[N+3:4], exp[3:0]);
            else passed++;
            held = exp;
        end
        // Backpressure: a new request is waiting but the consumer stalls for 3 cycles
        rop = 4'd4;
        ra  = $urandom;
        rb  = $urandom;
        exp = model(rop, ra, rb);
        @(negedge clk);
        out_ready = 1'b0;
        op = rop; a = ra; b = rb; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready);
            else passed++;
            total++;
            if (out_valid !== 1'b1 || {result, z, c, v, n} !== held)
                $display("[TB] FAIL stall_hold[%0d]: got valid=%b res=%h expected valid=1 res=%h", i, out_valid, result, held[N+3:4]);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || {result, z, c, v, n} !== exp)
            $display("[TB] FAIL stall_release: got valid=%b res=%h expected valid=1 res=%h", out_valid, result, exp[N+3:4]);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("[TB] FAIL drain_to_idle: got out_valid=%b expected 0", out_valid);
        else passed++;
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        logic [N-1:0] ra, rb;
        logic [N+3:0] got, exp;
        int           lat;
        logic         to, wok;
        send_op(4'd10, 32'd12345, 32'd678, got, lat, to, wok);
        total++;
        if (to || got[N+3:4] !== 32'd8369910) $display("[TB] FAIL mul_directed: got %0d timeout=%b expected 8369910", got[N+3:4], to);
        else passed++;
        total++;
        if (lat != N) $display("[TB] FAIL mul_latency: got %0d expected %0d", lat, N);
        else passed++;
        total++;
        if (!wok) $display("[TB] FAIL mul_busy: got busy/in_ready wrong while iterating expected busy=1 in_ready=0");
        else passed++;
        for (int i = 0; i < 4; i++) begin
            ra  = pick();
            rb  = pick();
            exp = model(4'd10, ra, rb);
            send_op(4'd10, ra, rb, got, lat, to, wok);
            total++;
            if (to || got !== exp) $display("[TB] FAIL mul_random a=%h b=%h: got %h expected %h", ra, rb, got, exp);
            else passed++;
        end
    endtask

    task automatic test_mul_reset();
        logic [N+3:0] got, exp;
        int           lat;
        logic         to, wok;
        @(negedge clk);
        op = 4'd10; a = 32'd99; b = 32'd77; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, in_ready} !== 3'b000 || {result, z, c, v, n} !== '0)
            $display("[TB] FAIL mul_reset: got valid=%b busy=%b in_ready=%b res=%h expected all 0", out_valid, busy, in_ready, result);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        exp = model(4'd0, 32'd40, 32'd2);
        send_op(4'd0, 32'd40, 32'd2, got, lat, to, wok);
        total++;
        if (to || lat != 0 || got !== exp) $display("[TB] FAIL after_reset_add: got %h lat=%0d expected %h lat=0", got, lat, exp);
        else passed++;
    endtask
`else
    task automatic test_undefined_op();
        logic [N+3:0] got;
        int           lat;
        logic         to, wok;
        send_op(4'd10, 32'd12345, 32'd678, got, lat, to, wok);
        total++;
        if (to || lat != 0 || got !== {32'd0, 4'b1000})
            $display("[TB] FAIL op1010_no_mul: got res=%h zcvn=%b lat=%0d expected res=0 zcvn=1000 lat=0", got[N+3:4], got[3:0], lat);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL busy_tied: got %b expected 0", busy);
        else passed++;
    endtask
`endif

    // Test sequence
    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
`ifdef ALU_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_undefined_op();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
